// File: rtl/if_id_decode_buffer.sv
// rtl/if_id_decode_buffer.sv - IF/ID two-entry elastic buffer with MIPS field decode
// Head register plus one skid slot; the head is what decode sees, the skid absorbs one stalled push.
module if_id_decode_buffer #(
    parameter int PC_WIDTH        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [31:0]                imm_sext,
    output logic [25:0]                jump_index,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                     state_q;
    logic                       valid_q;
    logic [31:0]                head_instr_q;
    logic [PC_WIDTH-1:0]        head_pc_q;
    logic [31:0]                skid_instr_q;
    logic [PC_WIDTH-1:0]        skid_pc_q;
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    logic push;
    logic pop;

    // in_ready depends only on registered state and RESET, never on out_ready.
    assign in_ready = !RESET && (state_q != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = valid_q && out_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= EMPTY;
            valid_q      <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            stall_q      <= '0;
        end else begin
            if (valid_q && !out_ready && !flush && (stall_q != '1))
                stall_q <= stall_q + 1'b1;

            // Head data is left untouched on flush/drain so out_* hold their last value.
            if (flush) begin
                state_q <= EMPTY;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            head_instr_q <= in_instruction;
                            head_pc_q    <= in_pc;
                            state_q      <= ONE;
                            valid_q      <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_instr_q <= in_instruction;
                            head_pc_q    <= in_pc;
                        end else if (push) begin
                            skid_instr_q <= in_instruction;
                            skid_pc_q    <= in_pc;
                            state_q      <= FULL;
                        end else if (pop) begin
                            state_q <= EMPTY;
                            valid_q <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head_instr_q <= skid_instr_q;
                            head_pc_q    <= skid_pc_q;
                            state_q      <= ONE;
                        end
                    end
                    default: begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_instruction = head_instr_q;
    assign out_pc          = head_pc_q;
    assign stall_count     = stall_q;

    assign opcode     = head_instr_q[31:26];
    assign rs         = head_instr_q[25:21];
    assign rt         = head_instr_q[20:16];
    assign rd         = head_instr_q[15:11];
    assign shamt      = head_instr_q[10:6];
    assign funct      = head_instr_q[5:0];
    assign imm_sext   = {{16{head_instr_q[15]}}, head_instr_q[15:0]};
    assign jump_index = head_instr_q[25:0];

endmodule
